mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-ported ideal memory (one write port plus one read port used) between the CPU's instruction-fetch (IF) and data-memory (DM) requesters. Each requester uses a valid/ready request handshake and a valid/ready response handshake. The block sequences one access at a time with a 3-state FSM and round-robin arbitration. It sits between the MIPS CPU core and ideal_mem in the perf-counter evaluation top.

Parameters:
ADDR_WIDTH, 14, byte-address width of memory; word address is ADDR_WIDTH-2 bits.

Ports:
clk  in  1  CPU source clock.
resetn  in  1  asynchronous active-low reset.
if_req_valid  in  1  IF request valid.
if_req_ready  out  1  IF request accepted this cycle.
if_req_addr  in  32  IF byte address.
if_resp_valid  out  1  IF read data valid.
if_resp_ready  in  1  IF consumes response.
if_resp_rdata  out  32  IF read data.
dm_req_valid  in  1  DM request valid.
dm_req_ready  out  1  DM request accepted.
dm_req_addr  in  32  DM byte address.
dm_req_wen  in  1  1 = store, 0 = load.
dm_req_wdata  in  32  store data.
dm_resp_valid  out  1  DM response valid (load data or store ack).
dm_resp_ready  in  1  DM consumes response.
dm_resp_rdata  out  32  DM load data; 0 for store ack.
mem_addr  out  ADDR_WIDTH-2  word address, driven to Waddr and Raddr1.
mem_wren  out  1  to Wren.
mem_rden  out  1  to Rden1.
mem_wdata  out  32  to Wdata.
mem_rdata  in  32  from Rdata1 (combinational read).

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; last_grant=IF; all outputs 0; latched addr/wdata/wen cleared. A reset asserted in ACCESS before the clock edge suppresses the write. A reset in RESP discards the pending response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Ready is combinational and goes only to the winner, and only when that requester's valid is high.
  - Winner when one requester is valid: that requester.
  - Winner when both are valid: the requester not in last_grant. After reset, DM wins the first conflict.
  - On handshake: latch word addr = addr[ADDR_WIDTH-1:2], and wen/wdata (IF wen is forced 0). Update last_grant and owner; go to ACCESS.
  - Low address bits [1:0] are ignored. Bits above ADDR_WIDTH-1 are truncated.
- ACCESS, exactly one cycle:
  - mem_addr = latched addr; mem_wren = latched wen; mem_rden = ~latched wen; mem_wdata = latched wdata.
  - On the edge: the write commits in memory; resp_data <= wen ? 0 : mem_rdata. Go to RESP.
  - All ready outputs are 0.
- RESP:
  - The owner's resp_valid=1 with rdata=resp_data, held stable until resp_ready=1.
  - mem_wren/mem_rden=0; ready outputs 0.
  - On the handshake edge: go to IDLE. No new request is accepted in the handshake cycle.
- Latency: request handshake at cycle N; resp_valid first high at cycle N+2. Minimum 3 cycles per access; back-to-back throughput is 1 access per 3 cycles.
- Memory side: at most one of mem_wren and mem_rden is high, and only in ACCESS.
- Requester inputs are sampled only at the handshake; changes after acceptance have no effect.
- resp_valid stays high indefinitely under back-pressure. The other requester stalls; no starvation occurs since round-robin applies at each IDLE.

Optional Feature:
Macro: ARB_PERF_CNT_EN.
- Defined: adds output ports perf_if_grants, perf_dm_grants, perf_if_wait and perf_dm_wait, each 32 bits.
  - perf_if_grants / perf_dm_grants: count of accepted requests.
  - perf_if_wait / perf_dm_wait: count of cycles the requester's req_valid=1 && req_ready=0.
  - All counters clear on reset and wrap modulo 2^32.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
1. Single IF load: after reset, IF addr 0x10 (mem[4]=0x241d0400) handshakes at cycle N -> if_resp_valid at N+2 with rdata 0x241d0400; mem_rden=1 only at N+1.
2. DM store then load: store 0x0000abcd to 0x220, then load 0x220 -> store ack rdata=0; load returns 0x0000abcd; mem_wren high for exactly one cycle.
3. Simultaneous requests: both valid continuously from reset -> grant order DM, IF, DM, IF; each access 3 cycles apart.
4. Response back-pressure: hold dm_resp_ready=0 for 5 cycles -> dm_resp_valid and rdata stable; if_req_ready stays 0; IF granted in the cycle after the DM response handshake completes.
5. Reset mid-ACCESS with a DM store: resetn dropped before the edge -> memory unchanged; all outputs 0 immediately; first conflict after release goes to DM.
6. With ARB_PERF_CNT_EN defined, run scenario 3 for 4 grants -> perf_if_grants=2, perf_dm_grants=2, and the wait counters equal the measured stall cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported ideal memory between the CPU instruction-fetch
//   (IF) and data-memory (DM) requesters. Each requester has a valid/ready
//   request channel and a valid/ready response channel. One access is in
//   flight at a time. A three-state FSM (IDLE -> ACCESS -> RESP) sequences
//   the accesses. Round-robin arbitration decides when both requesters ask.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   if_req_*  / if_resp_*  IF request (addr) and response (rdata) channels
//   dm_req_*  / dm_resp_*  DM request (addr, wen, wdata) and response channels
//   mem_addr               word address to the memory Waddr/Raddr1
//   mem_wren, mem_rden     write enable / read enable, high only in ACCESS
//   mem_wdata              store data to the memory
//   mem_rdata              combinational read data from the memory
//
// Optional build macro ARB_PERF_CNT_EN:
//   Adds the perf_if_grants, perf_dm_grants, perf_if_wait and perf_dm_wait
//   32-bit counters as extra output ports.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [31:0]           if_req_addr,
  output logic                  if_resp_valid,
  input  logic                  if_resp_ready,
  output logic [31:0]           if_resp_rdata,
  input  logic                  dm_req_valid,
  output logic                  dm_req_ready,
  input  logic [31:0]           dm_req_addr,
  input  logic                  dm_req_wen,
  input  logic [31:0]           dm_req_wdata,
  output logic                  dm_resp_valid,
  input  logic                  dm_resp_ready,
  output logic [31:0]           dm_resp_rdata,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_if_grants,
  output logic [31:0]           perf_dm_grants,
  output logic [31:0]           perf_if_wait,
  output logic [31:0]           perf_dm_wait
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  state_t      state_r;
  logic        last_grant_r;
  logic        owner_r;
  logic        wen_r;

  logic        idle_s;
  logic        if_win_s;
  logic        dm_win_s;
  logic        resp_hs_s;
  logic [31:0] sel_addr_s;
  logic        sel_wen_s;
  logic [31:0] sel_wdata_s;
  logic        unused_s;

  // The readiness term includes resetn so that both ready outputs drop
  // immediately when reset is asserted, even with requests held high.
  assign idle_s   = resetn & (state_r == ST_IDLE);
  assign if_win_s = if_req_valid & (~dm_req_valid | (last_grant_r == GRANT_DM));
  assign dm_win_s = dm_req_valid & (~if_req_valid | (last_grant_r == GRANT_IF));

  assign if_req_ready = idle_s & if_win_s;
  assign dm_req_ready = idle_s & dm_win_s;

  assign resp_hs_s = (owner_r == GRANT_DM) ? dm_resp_ready : if_resp_ready;

  // The byte-offset bits and the bits above the memory range are dropped on purpose.
  assign unused_s = ^{sel_addr_s[31:ADDR_WIDTH], sel_addr_s[1:0]};

  // Select the request fields of the requester that wins this cycle.
  always_comb begin
    sel_addr_s  = if_req_addr;
    sel_wen_s   = 1'b0;
    sel_wdata_s = 32'h0000_0000;
    if (dm_req_ready) begin
      sel_addr_s  = dm_req_addr;
      sel_wen_s   = dm_req_wen;
      sel_wdata_s = dm_req_wdata;
    end else begin
      sel_addr_s  = if_req_addr;
      sel_wen_s   = 1'b0;
      sel_wdata_s = 32'h0000_0000;
    end
  end

  // Access sequencer: latches the request, drives one memory cycle, holds the response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= GRANT_IF;
      owner_r       <= GRANT_IF;
      wen_r         <= 1'b0;
      mem_addr      <= '0;
      mem_wren      <= 1'b0;
      mem_rden      <= 1'b0;
      mem_wdata     <= 32'h0000_0000;
      if_resp_valid <= 1'b0;
      if_resp_rdata <= 32'h0000_0000;
      dm_resp_valid <= 1'b0;
      dm_resp_rdata <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (if_req_ready | dm_req_ready) begin
            mem_addr     <= sel_addr_s[ADDR_WIDTH-1:2];
            wen_r        <= sel_wen_s;
            mem_wren     <= sel_wen_s;
            mem_rden     <= ~sel_wen_s;
            mem_wdata    <= sel_wdata_s;
            owner_r      <= dm_req_ready;
            last_grant_r <= dm_req_ready;
            state_r      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The memory samples the write on this edge; the read is combinational.
          mem_wren <= 1'b0;
          mem_rden <= 1'b0;
          if (owner_r == GRANT_DM) begin
            dm_resp_valid <= 1'b1;
            dm_resp_rdata <= wen_r ? 32'h0000_0000 : mem_rdata;
          end else begin
            if_resp_valid <= 1'b1;
            if_resp_rdata <= mem_rdata;
          end
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_hs_s) begin
            if_resp_valid <= 1'b0;
            if_resp_rdata <= 32'h0000_0000;
            dm_resp_valid <= 1'b0;
            dm_resp_rdata <= 32'h0000_0000;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_wren <= 1'b0;
          mem_rden <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Grant and stall counters; all wrap naturally at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_if_grants <= 32'd0;
      perf_dm_grants <= 32'd0;
      perf_if_wait   <= 32'd0;
      perf_dm_wait   <= 32'd0;
    end else begin
      if (if_req_valid & if_req_ready) begin
        perf_if_grants <= perf_if_grants + 32'd1;
      end
      if (dm_req_valid & dm_req_ready) begin
        perf_dm_grants <= perf_dm_grants + 32'd1;
      end
      if (if_req_valid & ~if_req_ready) begin
        perf_if_wait <= perf_if_wait + 32'd1;
      end
      if (dm_req_valid & ~dm_req_ready) begin
        perf_dm_wait <= perf_dm_wait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. It uses a behavioural ideal
// memory with a combinational read and a write on the clock edge. A table
// of single-access vectors drives the main checks. Hand-written sequences
// cover the arbitration order, response back-pressure and reset during an
// access.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam logic [1:0] OWN_IF = 2'd1;
  localparam logic [1:0] OWN_DM = 2'd2;

  typedef struct {
    logic        if_v;
    logic [31:0] if_a;
    logic        dm_v;
    logic [31:0] dm_a;
    logic        dm_w;
    logic [31:0] dm_d;
    logic [1:0]  exp_own;
    logic [11:0] exp_maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
  logic [31:0] if_req_addr, if_resp_rdata;
  logic        dm_req_valid, dm_req_ready, dm_req_wen, dm_resp_valid, dm_resp_ready;
  logic [31:0] dm_req_addr, dm_req_wdata, dm_resp_rdata;
  logic [11:0] mem_addr;
  logic        mem_wren, mem_rden;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_dm_grants, perf_if_wait, perf_dm_wait;
`endif

  logic [31:0] mem [0:4095];
  logic        mem_init_done = 1'b0;

  int          pass_cnt;
  int          total_cnt;
  vec_t        vecs [0:6];
  vec_t        v;
  logic        exp_rden, exp_wren;
  int          gcnt;
  logic        gwho [0:3];
  int          gcyc [0:3];
  int          if_wait_m, dm_wait_m;

  mem_port_arbiter #(.ADDR_WIDTH(14)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_ready (if_resp_ready),
    .if_resp_rdata (if_resp_rdata),
    .dm_req_valid  (dm_req_valid),
    .dm_req_ready  (dm_req_ready),
    .dm_req_addr   (dm_req_addr),
    .dm_req_wen    (dm_req_wen),
    .dm_req_wdata  (dm_req_wdata),
    .dm_resp_valid (dm_resp_valid),
    .dm_resp_ready (dm_resp_ready),
    .dm_resp_rdata (dm_resp_rdata),
    .mem_addr      (mem_addr),
    .mem_wren      (mem_wren),
    .mem_rden      (mem_rden),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_grants(perf_if_grants),
    .perf_dm_grants(perf_dm_grants),
    .perf_if_wait  (perf_if_wait),
    .perf_dm_wait  (perf_dm_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal memory: filled on the first edge, then written when mem_wren is high.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4096; i++) begin
        mem[i] <= (i == 4) ? 32'h241d_0400 : (32'hA500_0000 | 32'(i));
      end
      mem_init_done <= 1'b1;
    end else if (mem_wren) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req_valid  = 1'b0;
    if_req_addr   = 32'h0;
    dm_req_valid  = 1'b0;
    dm_req_addr   = 32'h0;
    dm_req_wen    = 1'b0;
    dm_req_wdata  = 32'h0;
    if_resp_ready = 1'b1;
    dm_resp_ready = 1'b1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    //            if_v  if_a          dm_v  dm_a          w     wdata         own     maddr   rdata
    vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0,        1'b0, 32'h0,        OWN_IF, 12'h004, 32'h241d_0400};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_0220, 1'b1, 32'h0000_abcd, OWN_DM, 12'h088, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h0000_0220, 1'b0, 32'h0,        OWN_DM, 12'h088, 32'h0000_abcd};
    vecs[3] = '{1'b1, 32'h0000_0223, 1'b0, 32'h0,        1'b0, 32'h0,        OWN_IF, 12'h088, 32'h0000_abcd};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 32'hFFFF_C00C, 1'b0, 32'h0,        OWN_DM, 12'h003, 32'hA500_0003};
    vecs[5] = '{1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0, 32'h0,        OWN_IF, 12'h002, 32'hA500_0002};
    vecs[6] = '{1'b1, 32'h0000_0008, 1'b1, 32'h0000_0014, 1'b0, 32'h0,        OWN_DM, 12'h005, 32'hA500_0005};

    // Reset state, with both requests asserted to show ready stays low.
    idle_inputs();
    resetn       = 1'b0;
    if_req_valid = 1'b1;
    dm_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_ready",  {31'd0, if_req_ready},  32'd0);
    check("rst_dm_ready",  {31'd0, dm_req_ready},  32'd0);
    check("rst_mem_wren",  {31'd0, mem_wren},      32'd0);
    check("rst_mem_rden",  {31'd0, mem_rden},      32'd0);
    check("rst_mem_addr",  {20'd0, mem_addr},      32'd0);
    check("rst_if_resp_v", {31'd0, if_resp_valid}, 32'd0);
    check("rst_dm_resp_v", {31'd0, dm_resp_valid}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    resetn = 1'b1;

    // Table-driven single accesses.
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      exp_wren = (v.exp_own == OWN_DM) & v.dm_w;
      exp_rden = ~exp_wren;
      if_req_valid = v.if_v;
      if_req_addr  = v.if_a;
      dm_req_valid = v.dm_v;
      dm_req_addr  = v.dm_a;
      dm_req_wen   = v.dm_w;
      dm_req_wdata = v.dm_d;
      @(negedge clk);
      check($sformatf("v%0d_if_ready", i), {31'd0, if_req_ready}, {31'd0, (v.exp_own == OWN_IF)});
      check($sformatf("v%0d_dm_ready", i), {31'd0, dm_req_ready}, {31'd0, (v.exp_own == OWN_DM)});
      check($sformatf("v%0d_n_rden", i), {31'd0, mem_rden}, 32'd0);
      check($sformatf("v%0d_n_wren", i), {31'd0, mem_wren}, 32'd0);
      @(posedge clk); #1;
      if_req_valid = 1'b0;
      dm_req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_acc_rden", i), {31'd0, mem_rden}, {31'd0, exp_rden});
      check($sformatf("v%0d_acc_wren", i), {31'd0, mem_wren}, {31'd0, exp_wren});
      check($sformatf("v%0d_acc_addr", i), {20'd0, mem_addr}, {20'd0, v.exp_maddr});
      check($sformatf("v%0d_acc_ready", i), {30'd0, if_req_ready, dm_req_ready}, 32'd0);
      if (exp_wren) begin
        check($sformatf("v%0d_acc_wdata", i), mem_wdata, v.dm_d);
      end
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("v%0d_resp_valid", i), {30'd0, if_resp_valid, dm_resp_valid},
            (v.exp_own == OWN_IF) ? 32'd2 : 32'd1);
      check($sformatf("v%0d_resp_rdata", i),
            (v.exp_own == OWN_IF) ? if_resp_rdata : dm_resp_rdata, v.exp_rdata);
      check($sformatf("v%0d_resp_mem_en", i), {30'd0, mem_wren, mem_rden}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("v%0d_idle_resp", i), {30'd0, if_resp_valid, dm_resp_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Continuous conflict from reset: grants DM, IF, DM, IF three cycles apart.
    resetn = 1'b0;
    idle_inputs();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0010;
    dm_req_valid = 1'b1;
    dm_req_addr  = 32'h0000_0220;
    repeat (2) @(posedge clk);
    #1;
    resetn    = 1'b1;
    gcnt      = 0;
    if_wait_m = 0;
    dm_wait_m = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if_req_valid && !if_req_ready) if_wait_m++;
      if (dm_req_valid && !dm_req_ready) dm_wait_m++;
      if (dm_req_ready || if_req_ready) begin
        if (gcnt < 4) begin
          gwho[gcnt] = dm_req_ready;
          gcyc[gcnt] = k;
        end
        gcnt++;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    check("rr_grant_count", gcnt, 32'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rr_who%0d", j), {31'd0, gwho[j]}, (j % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_cyc%0d", j), gcyc[j], 32'(3 * j));
    end
    check("rr_if_wait", if_wait_m, 32'd10);
    check("rr_dm_wait", dm_wait_m, 32'd10);
`ifdef ARB_PERF_CNT_EN
    @(negedge clk);
    check("perf_if_grants", perf_if_grants, 32'd2);
    check("perf_dm_grants", perf_dm_grants, 32'd2);
    check("perf_if_wait",   perf_if_wait,   if_wait_m);
    check("perf_dm_wait",   perf_dm_wait,   dm_wait_m);
    @(posedge clk); #1;
`endif

    // Response back-pressure on DM; IF waits until the DM response handshake completes.
    resetn = 1'b0;
    idle_inputs();
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h0000_0010;
    dm_req_valid  = 1'b1;
    dm_req_addr   = 32'h0000_0220;
    dm_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("bp_dm_grant", {31'd0, dm_req_ready}, 32'd1);
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", k), {31'd0, dm_resp_valid}, 32'd1);
      check($sformatf("bp_rdata%0d", k), dm_resp_rdata, 32'h0000_abcd);
      check($sformatf("bp_if_ready%0d", k), {31'd0, if_req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    dm_resp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", {31'd0, dm_resp_valid}, 32'd1);
    check("bp_hs_if_ready", {31'd0, if_req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_valid", {31'd0, dm_resp_valid}, 32'd0);
    check("bp_after_if_ready", {31'd0, if_req_ready}, 32'd1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_if_resp_valid", {31'd0, if_resp_valid}, 32'd1);
    check("bp_if_resp_rdata", if_resp_rdata, 32'h241d_0400);
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a DM store: the write must not happen.
    dm_req_valid = 1'b1;
    dm_req_addr  = 32'h0000_0040;
    dm_req_wen   = 1'b1;
    dm_req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rs_dm_grant", {31'd0, dm_req_ready}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    #2;
    check("rs_pre_wren", {31'd0, mem_wren}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rs_wren",  {31'd0, mem_wren},  32'd0);
    check("rs_rden",  {31'd0, mem_rden},  32'd0);
    check("rs_addr",  {20'd0, mem_addr},  32'd0);
    check("rs_wdata", mem_wdata,          32'd0);
    @(posedge clk); #1;
    check("rs_mem_unchanged", mem[16], 32'hA500_0010);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0010;
    dm_req_valid = 1'b1;
    dm_req_addr  = 32'h0000_0220;
    @(negedge clk);
    check("rs_held_ready", {30'd0, if_req_ready, dm_req_ready}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rs_first_dm", {31'd0, dm_req_ready}, 32'd1);
    check("rs_first_if", {31'd0, if_req_ready}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
